// File: rtl/xps2_tx.sv
`default_nettype none
// ============================================================================
// xps2_tx : PS/2 host-to-device transmitter driving open-drain pad enables.
// Optional watchdog enabled by defining XPS2TX_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module xps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [1:0] data_out,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int               INH_W    = $clog2(INHIBIT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);

    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048576) begin : g_param_check
        $error("xps2_tx: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           state_q;
    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_last_q;
    logic             fall_q;
    logic [9:0]       frame_q;
    logic [3:0]       bit_q;
    logic [INH_W-1:0] inh_q;
    logic             busy_q;
    logic             err_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             accept;
    logic             parity_d;
    logic             wd_hit;

    assign accept      = sel & we & ~busy_q;
    assign parity_d    = ~^data_in;
    assign data_out    = {err_q, busy_q};
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // Idle line level is high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_last_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_last_q  <= clk_sync_q[1];
            fall_q      <= clk_last_q & ~clk_sync_q[1];
        end
    end

`ifdef XPS2TX_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] wd_q;
    logic        wd_active;

    assign wd_active = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_hit    = wd_active && (wd_q == WD_LAST);

    // Held at zero through INHIBIT so the count starts at INHIBIT exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= 20'd0;
        end else if (accept || state_q == S_INHIBIT) begin
            wd_q <= 20'd0;
        end else if (wd_active && !wd_hit) begin
            wd_q <= wd_q + 20'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= 10'd0;
            bit_q     <= 4'd0;
            inh_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else if (wd_hit) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (accept) begin
                        frame_q  <= {1'b1, parity_d, data_in};
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        inh_q    <= '0;
                        bit_q    <= 4'd0;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    inh_q <= inh_q + INH_W'(1);
                    if (inh_q == INH_PRE) begin
                        data_oe_q <= 1'b1;
                    end
                    if (inh_q == INH_LAST) begin
                        clk_oe_q <= 1'b0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (fall_q) begin
                        data_oe_q <= ~frame_q[0];
                        bit_q     <= 4'd1;
                        state_q   <= S_SHIFT;
                    end
                end
                // frame_q[9] is the stop bit, so the 10th edge releases the line.
                S_SHIFT: begin
                    if (fall_q) begin
                        data_oe_q <= ~frame_q[bit_q];
                        if (bit_q == 4'd9) begin
                            state_q <= S_ACK;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (fall_q) begin
                        err_q   <= data_sync_q[1];
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_sync_q[1] && data_sync_q[1]) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
